bus_rv32_fabric: RTL

Parametrised single-master bus fabric placed between the RV32 CPU core and its memory-mapped peripherals. It replaces the fixed point-to-point CPU bus with the following features:
- address decode onto `NUM_SLAVES` peripheral windows;
- a ready/wait-state handshake with optional timeout;
- registered read-data return;
- an edge-captured, maskable interrupt aggregator exposed in its own register window.

---
 rtl/bus_rv32_fabric.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/bus_rv32_fabric.sv
// Purpose: single-master RV32 bus fabric: window decode, wait-state handshake, IRQ aggregator.
// Latency: slave access >= 2 cycles (ready+1); internal/unmapped access 1 cycle.
// Backpressure: one transfer in flight; cpu_req_i sampled only in IDLE, slaves stall via slv_ready_i.
//
// Ports:
//   clk_i / reset_i            : clock, asynchronous active-low reset
//   cpu_*                      : CPU side request / completion / interrupt
//   slv_*                      : peripheral side select, write data, packed read data, ready, irq
// Optional feature: define BUS_FABRIC_TIMEOUT_EN to bound ACCESS at TIMEOUT_CYCLES cycles
// (timeout completes with cpu_err_o=1). Without it ACCESS waits indefinitely.
// Windows: index = address[ADDR_WIDTH-1:REGION_BITS]; 0..NUM_SLAVES-1 = slaves,
// NUM_SLAVES = IRQ registers (ENABLE, PENDING w1c, RAW, reserved at offset [3:2]).

module bus_rv32_fabric #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_SLAVES     = 4,
    parameter int REGION_BITS    = 12,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic                             cpu_req_i,
    input  logic                             cpu_we_i,
    input  logic [ADDR_WIDTH-1:0]            cpu_address_i,
    input  logic [DATA_WIDTH-1:0]            cpu_data_i,
    output logic [DATA_WIDTH-1:0]            cpu_data_o,
    output logic                             cpu_ready_o,
    output logic                             cpu_err_o,
    output logic                             cpu_irq_o,
    output logic [NUM_SLAVES-1:0]            slv_sel_o,
    output logic                             slv_we_o,
    output logic [REGION_BITS-1:0]           slv_address_o,
    output logic [DATA_WIDTH-1:0]            slv_data_o,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] slv_data_i,
    input  logic [NUM_SLAVES-1:0]            slv_ready_i,
    input  logic [NUM_SLAVES-1:0]            slv_irq_i
);

    localparam int IDX_W = ADDR_WIDTH - REGION_BITS;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t state_q, state_d;

    // ---------------------------------------------------------------- decode
    logic [IDX_W-1:0]      win_idx;
    logic                  hit_slave;
    logic                  hit_irq;
    logic [NUM_SLAVES-1:0] dec_onehot;
    logic                  req_go;

    assign win_idx   = cpu_address_i[ADDR_WIDTH-1:REGION_BITS];
    assign hit_slave = (win_idx < IDX_W'(NUM_SLAVES));
    assign hit_irq   = (win_idx == IDX_W'(NUM_SLAVES));
    assign req_go    = (state_q == S_IDLE) && cpu_req_i;

    always_comb begin
        dec_onehot = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            dec_onehot[k] = (win_idx == IDX_W'(k));
        end
    end

    // ------------------------------------------------------- latched request
    logic [NUM_SLAVES-1:0]  sel_q;
    logic                   we_q;
    logic [REGION_BITS-1:0] addr_q;
    logic [DATA_WIDTH-1:0]  wdat_q;
    logic [DATA_WIDTH-1:0]  rdat_q;
    logic                   err_q;

    // Only the selected slave's ready counts; other slaves' strobes are ignored.
    logic                  ready_hit;
    logic [DATA_WIDTH-1:0] rsel_dat;

    assign ready_hit = |(slv_ready_i & sel_q);

    always_comb begin
        rsel_dat = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (sel_q[k]) begin
                rsel_dat = rsel_dat | slv_data_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // ---------------------------------------------------------- timeout
    logic tmo_hit;
`ifdef BUS_FABRIC_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] tmo_cnt_q;

    // Counter value k means k ACCESS cycles already elapsed without ready.
    assign tmo_hit = (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            tmo_cnt_q <= '0;
        end else if (req_go) begin
            tmo_cnt_q <= '0;
        end else if (state_q == S_ACCESS && !tmo_hit) begin
            tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // ---------------------------------------------------------- IRQ block
    logic [NUM_SLAVES-1:0] enable_q;
    logic [NUM_SLAVES-1:0] pending_q;
    logic [NUM_SLAVES-1:0] irq_d_q;
    logic [NUM_SLAVES-1:0] irq_rise;
    logic [NUM_SLAVES-1:0] pend_clr;
    logic                  reg_wr;
    logic [1:0]            reg_off;
    logic [DATA_WIDTH-1:0] reg_rdat;

    assign reg_off  = cpu_address_i[3:2];
    assign reg_wr   = req_go && hit_irq && cpu_we_i;
    assign irq_rise = slv_irq_i & ~irq_d_q;
    assign pend_clr = (reg_wr && reg_off == 2'd1) ? cpu_data_i[NUM_SLAVES-1:0] : '0;

    always_comb begin
        reg_rdat = '0;
        case (reg_off)
            2'd0:    reg_rdat = DATA_WIDTH'(enable_q);
            2'd1:    reg_rdat = DATA_WIDTH'(pending_q);
            2'd2:    reg_rdat = DATA_WIDTH'(slv_irq_i);
            default: reg_rdat = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            enable_q  <= '0;
            pending_q <= '0;
            irq_d_q   <= '0;
            cpu_irq_o <= 1'b0;
        end else begin
            irq_d_q   <= slv_irq_i;
            // A new edge beats a simultaneous write-1-to-clear.
            pending_q <= (pending_q & ~pend_clr) | irq_rise;
            if (reg_wr && reg_off == 2'd0) begin
                enable_q <= cpu_data_i[NUM_SLAVES-1:0];
            end
            cpu_irq_o <= |(pending_q & enable_q);
        end
    end

    // ---------------------------------------------------------- datapath
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            sel_q  <= '0;
            we_q   <= 1'b0;
            addr_q <= '0;
            wdat_q <= '0;
            rdat_q <= '0;
            err_q  <= 1'b0;
        end else if (req_go) begin
            sel_q  <= dec_onehot;
            we_q   <= cpu_we_i;
            addr_q <= cpu_address_i[REGION_BITS-1:0];
            wdat_q <= cpu_data_i;
            if (!hit_slave) begin
                rdat_q <= (hit_irq && !cpu_we_i) ? reg_rdat : '0;
                err_q  <= !hit_irq;
            end
        end else if (state_q == S_ACCESS) begin
            if (ready_hit) begin
                rdat_q <= we_q ? '0 : rsel_dat;
                err_q  <= 1'b0;
            end else if (tmo_hit) begin
                rdat_q <= '0;
                err_q  <= 1'b1;
            end
        end
    end

    // ---------------------------------------------------------- FSM
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (cpu_req_i) begin
                    state_d = hit_slave ? S_ACCESS : S_RESP;
                end
            end
            S_ACCESS: begin
                if (ready_hit || tmo_hit) begin
                    state_d = S_RESP;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cpu_ready_o   = (state_q == S_RESP);
        cpu_err_o     = (state_q == S_RESP) && err_q;
        cpu_data_o    = (state_q == S_RESP) ? rdat_q : '0;
        slv_sel_o     = (state_q == S_ACCESS) ? sel_q : '0;
        slv_we_o      = we_q;
        slv_address_o = addr_q;
        slv_data_o    = wdat_q;
    end

endmodule
